instr_fetch_unit: RTL and testbench



---
 rtl/mcu_pkg.sv | 25 ++
 rtl/fetch_fifo.sv | 66 ++++++
 rtl/instr_fetch_unit.sv | 107 ++++++++++
 tb/tb_instr_fetch_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_pkg.sv
// ============================================================================
// mcu_pkg : shared widths, opcode field position and fetch-state encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package mcu_pkg;

   localparam int INSTR_W    = 17;
   localparam int ADDR_W     = 8;
   localparam int OPCODE_MSB = 16;
   localparam int OPCODE_LSB = 12;
   localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

   localparam logic [OPCODE_W-1:0] HALT_OPCODE_DEFAULT = 5'h1F;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// fetch_fifo : synchronous FIFO with flush, head data exposed combinationally
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 25
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] storage [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;

   // DEPTH is a power of two, so pointers wrap naturally at PTR_W bits.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            storage[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            storage[wr_ptr] <= wr_data;
            wr_ptr          <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   assign rd_data = storage[rd_ptr];
   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// instr_fetch_unit : program counter, fetch FSM and decoder-facing buffer
// Rev 1.0
// ============================================================================
`default_nettype none

module instr_fetch_unit
   import mcu_pkg::*;
#(
   parameter int                  DEPTH       = 2,
   parameter logic [OPCODE_W-1:0] HALT_OPCODE = HALT_OPCODE_DEFAULT
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [ADDR_W-1:0]  start_pc,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_instr,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [ADDR_W-1:0]  out_pc,
   output logic               halted
);

   localparam int ENTRY_W = INSTR_W + ADDR_W;

   fetch_state_t        state;
   logic [ADDR_W-1:0]   fetch_pc;
   logic                fifo_full;
   logic                fifo_empty;
   logic                flush;
   logic                push;
   logic                pop;
   logic                is_halt;
   logic [ENTRY_W-1:0]  head;

   // A redirect voids any handshake in its cycle, so it suppresses both push and pop.
   assign flush   = redirect_valid & (state != ST_IDLE);
   assign pop     = ~fifo_empty & out_ready & ~flush;
   assign push    = (state == ST_RUN) & ~flush & (~fifo_full | pop);
   assign is_halt = (imem_instr[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE);

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .flush   (flush),
      .push    (push),
      .pop     (pop),
      .wr_data ({imem_instr, fetch_pc}),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         fetch_pc <= '0;
         halted   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  fetch_pc <= start_pc;
                  state    <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (flush) begin
                  fetch_pc <= redirect_pc;
               end else if (push) begin
                  fetch_pc <= fetch_pc + ADDR_W'(1);
                  if (is_halt) begin
                     state  <= ST_HALTED;
                     halted <= 1'b1;
                  end
               end
            end
            ST_HALTED: begin
               if (flush) begin
                  fetch_pc <= redirect_pc;
                  state    <= ST_RUN;
                  halted   <= 1'b0;
               end
            end
            default: begin
               state  <= ST_IDLE;
               halted <= 1'b0;
            end
         endcase
      end
   end

   assign imem_addr = fetch_pc;
   assign out_valid = ~fifo_empty;
   assign out_instr = head[ENTRY_W-1:ADDR_W];
   assign out_pc    = head[ADDR_W-1:0];

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// tb_instr_fetch_unit : queue-based reference model plus directed checks
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  start_pc = 8'h00;
   logic [7:0]  imem_addr;
   logic [16:0] imem_instr;
   logic        redirect_valid = 1'b0;
   logic [7:0]  redirect_pc = 8'h00;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [16:0] out_instr;
   logic [7:0]  out_pc;
   logic        halted;

   logic [16:0] mem [256];

   int checks = 0;
   int errors = 0;
   bit en = 1'b0;

   always #5 clk = ~clk;

   assign imem_instr = mem[imem_addr];

   instr_fetch_unit #(
      .DEPTH       (DEPTH),
      .HALT_OPCODE (5'h1F)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .start_pc       (start_pc),
      .imem_addr      (imem_addr),
      .imem_instr     (imem_instr),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .halted         (halted)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Inputs as seen by the DUT at the rising edge.
   logic       s_reset = 1'b1, s_start = 1'b0, s_redir = 1'b0, s_ready = 1'b0;
   logic [7:0] s_start_pc = 8'h00, s_redir_pc = 8'h00;

   always @(posedge clk) begin
      s_reset    <= reset;
      s_start    <= start;
      s_start_pc <= start_pc;
      s_redir    <= redirect_valid;
      s_redir_pc <= redirect_pc;
      s_ready    <= out_ready;
   end

   // Model: an ordered queue of {instr, pc}; mode 0 idle, 1 fetching, 2 halted.
   logic [24:0] mq[$];
   int          mmode = 0;
   logic [7:0]  mpc = 8'h00;

   initial begin
      logic [16:0] w;
      forever begin
         @(negedge clk);
         if (s_reset) begin
            mq.delete();
            mmode = 0;
            mpc   = 8'h00;
         end else if (mmode == 0) begin
            if (s_start) begin
               mpc   = s_start_pc;
               mmode = 1;
            end
         end else if (s_redir) begin
            mq.delete();
            mpc   = s_redir_pc;
            mmode = 1;
         end else begin
            if (mq.size() > 0 && s_ready) void'(mq.pop_front());
            if (mmode == 1 && mq.size() < DEPTH) begin
               w = mem[mpc];
               mq.push_back({w, mpc});
               if (w[16:12] == 5'h1F) mmode = 2;
               mpc = mpc + 8'd1;
            end
         end
         if (en) begin
            chk("m_out_valid", out_valid, mq.size() > 0);
            if (mq.size() > 0) begin
               chk("m_out_instr", out_instr, mq[0][24:8]);
               chk("m_out_pc", out_pc, mq[0][7:0]);
            end
            chk("m_imem_addr", imem_addr, mpc);
            chk("m_halted", halted, mmode == 2);
         end
      end
   end

   initial begin
      int n;
      for (int a = 0; a < 256; a++) mem[a] = 17'(a);

      repeat (2) @(negedge clk);
      reset = 1'b0;
      en    = 1'b1;
      @(negedge clk);
      chk("reset_valid", out_valid, 0);
      chk("reset_addr", imem_addr, 0);
      chk("reset_halted", halted, 0);
      chk("reset_instr", out_instr, 0);
      chk("reset_pc", out_pc, 0);

      redirect_valid = 1'b1; redirect_pc = 8'h77;
      @(negedge clk);
      redirect_valid = 1'b0;
      chk("idle_redirect_ignored", imem_addr, 0);

      start = 1'b1; start_pc = 8'h10; out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("lat_addr", imem_addr, 8'h10);
      chk("lat_valid", out_valid, 0);
      @(negedge clk);
      chk("first_valid", out_valid, 1);
      chk("first_pc", out_pc, 8'h10);
      chk("first_instr", out_instr, 17'h00010);
      @(negedge clk);
      chk("second_pc", out_pc, 8'h11);
      repeat (3) @(negedge clk);
      chk("stream_pc", out_pc, 8'h14);

      out_ready = 1'b0;
      repeat (5) @(negedge clk);
      chk("stall_addr", imem_addr, 8'h16);
      chk("stall_pc", out_pc, 8'h14);
      out_ready = 1'b1;
      @(negedge clk);
      chk("resume_pc", out_pc, 8'h15);
      repeat (2) @(negedge clk);

      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      redirect_valid = 1'b1; redirect_pc = 8'h40; out_ready = 1'b1;
      @(negedge clk);
      redirect_valid = 1'b0;
      chk("redir_addr", imem_addr, 8'h40);
      chk("redir_valid", out_valid, 0);
      @(negedge clk);
      chk("redir_first_valid", out_valid, 1);
      chk("redir_first_pc", out_pc, 8'h40);
      @(negedge clk);
      chk("redir_next_pc", out_pc, 8'h41);

      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rst_mid_valid", out_valid, 0);
      chk("rst_mid_addr", imem_addr, 0);
      chk("rst_mid_halted", halted, 0);
      repeat (3) @(negedge clk);
      chk("rst_idle_valid", out_valid, 0);

      start = 1'b1; start_pc = 8'hFE; redirect_valid = 1'b1; redirect_pc = 8'h30;
      @(negedge clk);
      start = 1'b0; redirect_valid = 1'b0;
      chk("start_wins_addr", imem_addr, 8'hFE);
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         chk("wrap_pc", out_pc, 8'(8'hFE + k));
         @(negedge clk);
      end

      reset = 1'b1;
      mem[5] = {5'h1F, 12'h000};
      @(negedge clk);
      reset = 1'b0;
      start = 1'b1; start_pc = 8'h00;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!halted && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("halt_reached", halted, 1);
      repeat (4) @(negedge clk);
      chk("halt_addr", imem_addr, 8'h06);
      chk("halt_drained", out_valid, 0);
      chk("halt_held", halted, 1);

      redirect_valid = 1'b1; redirect_pc = 8'h20;
      @(negedge clk);
      redirect_valid = 1'b0;
      chk("unhalt", halted, 0);
      chk("unhalt_addr", imem_addr, 8'h20);
      @(negedge clk);
      chk("unhalt_valid", out_valid, 1);
      chk("unhalt_pc", out_pc, 8'h20);
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
